div_unit: RTL and testbench

Multi-cycle signed divider that executes MIPS `div` for the multicycle CPU. The control unit initiates an operation with a one-cycle `DivCtrl` pulse and the operands from registers A and B. `div_unit` iterates one quotient bit per cycle, then returns the quotient for LO and the remainder for HI through the HI/LO input muxes. It also raises a divide-by-zero flag, which the control unit uses for its exception path.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 119 +++++++++++
 tb/tb_div_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU's iterative arithmetic units (div_unit, mult_unit).
package cpu_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int CNT_W     = $clog2(CPU_WIDTH) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_dvsr,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic        [WIDTH+1:0] w_shift;
    logic signed [WIDTH+1:0] w_diff;

    // Two guard bits keep the trial difference's sign unambiguous for any magnitude.
    always_comb begin
        w_shift = {i_rem, i_dvd_bit};
        w_diff  = signed'(w_shift) - signed'({2'b00, i_dvsr});
        o_qbit  = ~w_diff[WIDTH+1];
        o_rem   = o_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider for MIPS div: one quotient bit per cycle on magnitudes,
// signs applied in a final fix-up cycle. Quotient goes to LO, remainder to HI.
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int ITER_W = $clog2(WIDTH) + 1;

    div_state_t         r_state;
    div_state_t         w_next;
    logic               r_sign_dvd;
    logic               r_sign_dvsr;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH:0]     r_prem;
    logic [ITER_W-1:0]  r_cnt;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH:0]     w_step_rem;
    logic               w_qbit;
    logic               w_last;
    logic               w_dvsr_zero;

    function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    assign w_last      = (r_cnt == ITER_W'(WIDTH - 1));
    assign w_dvsr_zero = (divisor == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_prem),
        .i_dvd_bit (r_dvd[WIDTH-1]),
        .i_dvsr    (r_dvsr),
        .o_rem     (w_step_rem),
        .o_qbit    (w_qbit)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            DIV_IDLE: if (start) w_next = w_dvsr_zero ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (w_last) w_next = DIV_FIX;
            DIV_FIX:  w_next = DIV_DONE;
            DIV_DONE: w_next = DIV_IDLE;
            default:  w_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= DIV_IDLE;
        else        r_state <= w_next;
    end

    // r_dvd doubles as the quotient shift register: dividend bits leave the top as quotient bits enter the bottom.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sign_dvd  <= 1'b0;
            r_sign_dvsr <= 1'b0;
            r_dvd       <= '0;
            r_dvsr      <= '0;
            r_prem      <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_quo       <= '0;
            r_rem       <= '0;
        end else begin
            r_done <= (r_state == DIV_DONE);
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_sign_dvd  <= dividend[WIDTH-1];
                        r_sign_dvsr <= divisor[WIDTH-1];
                        r_dvd       <= neg_if(dividend[WIDTH-1], dividend);
                        r_dvsr      <= neg_if(divisor[WIDTH-1], divisor);
                        r_prem      <= '0;
                        r_cnt       <= '0;
                        r_div_zero  <= w_dvsr_zero;
                    end
                end
                DIV_CALC: begin
                    r_prem <= w_step_rem;
                    r_dvd  <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt  <= r_cnt + ITER_W'(1);
                end
                DIV_FIX: begin
                    r_quo <= neg_if(r_sign_dvd ^ r_sign_dvsr, r_dvd);
                    r_rem <= neg_if(r_sign_dvd, r_prem[WIDTH-1:0]);
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != DIV_IDLE) || r_done;
    assign done      = r_done;
    assign div_zero  = r_div_zero;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: signed results, latency, busy window, divide-by-zero, ignored start, reset abort.
module tb_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor  = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    div_unit #(
        .WIDTH (W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done after an accept; optionally pulses start=9/4 before cycle inject_at.
    task automatic wait_done(input int inject_at, output int lat, output int busy_low);
        lat      = 0;
        busy_low = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i == inject_at) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd4;
            end
            @(posedge clock); #1;
            if (i == inject_at) start = 1'b0;
            if (!busy) busy_low++;
            lat = i;
            if (done) break;
        end
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input int inject_at);
        int lat;
        int busy_low;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
        check({tag, "_busy_at_accept"}, W'(busy), W'(1));
        wait_done(inject_at, lat, busy_low);
        check({tag, "_latency"}, W'(lat), W'(34));
        check({tag, "_busy_low_cycles"}, W'(busy_low), W'(0));
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dz"}, W'(div_zero), W'(0));
        @(posedge clock); #1;
        check({tag, "_done_fall"}, W'(done), W'(0));
        check({tag, "_busy_fall"}, W'(busy), W'(0));
    endtask

    initial begin
        #12;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_dz", W'(div_zero), W'(0));
        check("rst_q", quotient, '0);
        check("rst_r", remainder, '0);
        reset = 1'b1;
        @(posedge clock); #1;

        run_div("p7_p2", 32'd7, 32'd2, 32'd3, 32'd1, 0);
        run_div("n7_p2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_div("p7_n2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
        run_div("min_n1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        run_div("zero_p5", 32'd0, 32'd5, 32'd0, 32'd0, 0);
        run_div("n100_n7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 0);
        run_div("ignored_start", 32'd7, 32'd2, 32'd3, 32'd1, 10);

        // 100 / 0 with prior results 3/1 held in quotient/remainder.
        dividend = 32'd100;
        divisor  = 32'd0;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        check("dz_flag_at_accept", W'(div_zero), W'(1));
        check("dz_busy_at_accept", W'(busy), W'(1));
        check("dz_done_early", W'(done), W'(0));
        @(posedge clock); #1;
        check("dz_done", W'(done), W'(1));
        check("dz_q_held", quotient, 32'd3);
        check("dz_r_held", remainder, 32'd1);
        check("dz_flag", W'(div_zero), W'(1));
        @(posedge clock); #1;
        check("dz_done_fall", W'(done), W'(0));
        check("dz_busy_fall", W'(busy), W'(0));
        check("dz_flag_held", W'(div_zero), W'(1));

        // Abort a running 50/7 at cycle 15 with reset.
        dividend = 32'd50;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        check("abort_dz_cleared", W'(div_zero), W'(0));
        repeat (15) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_dz", W'(div_zero), W'(0));
        check("abort_q", quotient, '0);
        check("abort_r", remainder, '0);
        #1;
        reset = 1'b1;
        run_div("after_rst_20_6", 32'd20, 32'd6, 32'd3, 32'd2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
